// File: rtl/led_pwm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_sequencer_pkg
//  Description : Shared encodings and helpers for the LED PWM sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pwm_sequencer_pkg;

   // Pattern selected on the Mode input
   typedef enum logic [1:0] {
      MODE_FIX10 = 2'd0,
      MODE_FIX50 = 2'd1,
      MODE_RAMP  = 2'd2,
      MODE_BLINK = 2'd3
   } mode_e;

   // Sequencer top-level state
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [3:0] DUTY_MAX        = 4'd10;
   localparam int         SLOTS_PER_FRAME = 10;
   localparam logic [3:0] SLOT_IDX_LAST   = 4'(SLOTS_PER_FRAME - 1);

   // Duty shown in the first frame after leaving IDLE
   function automatic logic [3:0] entry_duty(input mode_e mode);
      logic [3:0] duty;
      duty = 4'd1;
      case (mode)
         MODE_FIX10: duty = 4'd1;
         MODE_FIX50: duty = 4'd5;
         MODE_RAMP:  duty = 4'd0;
         MODE_BLINK: duty = DUTY_MAX;
      endcase
      return duty;
   endfunction

   // Modes that keep frame-to-frame sequencing state (level/step/direction)
   function automatic logic is_sequenced(input mode_e mode);
      return (mode == MODE_RAMP) || (mode == MODE_BLINK);
   endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_sequencer_if
//  Description : Board-side signal bundle of the LED PWM sequencer: switch and
//                mode inputs, LED drive and observation outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_pwm_sequencer_if;
   logic       Sw;
   logic [1:0] Mode;
   logic       Led;
   logic [3:0] Duty;
   logic       Frame_tick;

   // Board / stimulus side
   modport master (
      output Sw,
      output Mode,
      input  Led,
      input  Duty,
      input  Frame_tick
   );

   // Sequencer side
   modport slave (
      input  Sw,
      input  Mode,
      output Led,
      output Duty,
      output Frame_tick
   );
endinterface
`default_nettype wire

// File: rtl/led_pwm_sequencer_pwm_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_frame_timer
//  Description : Splits a PWM frame into SLOTS_PER_FRAME slots of SLOT_CYC
//                cycles each and flags the last cycle of the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_frame_timer
   import led_pwm_sequencer_pkg::*;
#(
   parameter int SLOT_CYC = 10
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   output logic [3:0] slot_idx,
   output logic       frame_tick
);

   localparam int               CNT_W     = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);

   logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
   logic [3:0]       slot_idx_q, slot_idx_d;
   logic             last_cyc_of_slot;

   assign last_cyc_of_slot = (slot_cnt_q == SLOT_LAST);
   assign frame_tick       = en && last_cyc_of_slot && (slot_idx_q == SLOT_IDX_LAST);
   assign slot_idx         = slot_idx_q;

   // Next-count logic: clear wins, otherwise advance while enabled
   always_comb begin
      slot_cnt_d = slot_cnt_q;
      slot_idx_d = slot_idx_q;
      if (clr) begin
         slot_cnt_d = '0;
         slot_idx_d = '0;
      end else if (en) begin
         if (last_cyc_of_slot) begin
            slot_cnt_d = '0;
            slot_idx_d = (slot_idx_q == SLOT_IDX_LAST) ? 4'd0 : slot_idx_q + 4'd1;
         end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt_q <= '0;
         slot_idx_q <= '0;
      end else begin
         slot_cnt_q <= slot_cnt_d;
         slot_idx_q <= slot_idx_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/led_pwm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_sequencer
//  Description : Frame-based LED PWM controller. Each frame is ten duty slots;
//                the duty level is re-evaluated only at frame end according to
//                the selected pattern (fixed 10 %, fixed 50 %, ramp, blink).
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_sequencer
   import led_pwm_sequencer_pkg::*;
#(
   parameter int CLK_HZ          = 50_000_000,
   parameter int FRAME_HZ        = 50,
   parameter int FRAMES_PER_STEP = 5
)
(
   input  logic                Clk_50M,
   input  logic                Rst,
   led_pwm_sequencer_if.slave  bus
);

   localparam int              SLOT_CYC  = CLK_HZ / (FRAME_HZ * SLOTS_PER_FRAME);
   localparam int              STEP_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic [3:0]        duty_q, duty_d;
   logic [3:0]        level_q, level_d;
   logic              dir_dn_q, dir_dn_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              led_q, led_d;

   logic              run;
   logic              timer_clr;
   logic [3:0]        slot_idx;
   logic              frame_tick;
   mode_e             mode_in;

   assign run       = (state_q == ST_RUN);
   assign timer_clr = !run || !bus.Sw;
   assign mode_in   = mode_e'(bus.Mode);

   pwm_frame_timer #(
      .SLOT_CYC (SLOT_CYC)
   ) u_frame_timer (
      .clk        (Clk_50M),
      .rst        (Rst),
      .clr        (timer_clr),
      .en         (run),
      .slot_idx   (slot_idx),
      .frame_tick (frame_tick)
   );

   // FSM next state, pattern sequencing at frame end and LED compare
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      duty_d   = duty_q;
      level_d  = level_q;
      dir_dn_d = dir_dn_q;
      step_d   = step_q;
      led_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            level_d  = '0;
            dir_dn_d = 1'b0;
            step_d   = '0;
            if (bus.Sw) begin
               state_d = ST_RUN;
               mode_d  = mode_in;
               duty_d  = entry_duty(mode_in);
               level_d = is_sequenced(mode_in) ? entry_duty(mode_in) : 4'd0;
            end
         end

         ST_RUN: begin
            if (!bus.Sw) begin
               // Leaving RUN freezes Duty; sequencing state restarts on re-entry
               state_d  = ST_IDLE;
               level_d  = '0;
               dir_dn_d = 1'b0;
               step_d   = '0;
            end else begin
               led_d = (slot_idx < duty_q);
               if (frame_tick) begin
                  mode_d = mode_in;
                  if (is_sequenced(mode_in) && (mode_in != mode_q)) begin
                     level_d  = '0;
                     dir_dn_d = 1'b0;
                     step_d   = '0;
                     duty_d   = '0;
                  end else begin
                     case (mode_in)
                        MODE_FIX10: duty_d = 4'd1;
                        MODE_FIX50: duty_d = 4'd5;
                        MODE_RAMP, MODE_BLINK: begin
                           if (step_q == STEP_LAST) begin
                              step_d = '0;
                              if (mode_in == MODE_BLINK) begin
                                 level_d = (level_q == 4'd0) ? DUTY_MAX : 4'd0;
                              end else if (!dir_dn_q) begin
                                 // Turn around on the top level so it is shown once
                                 if (level_q >= DUTY_MAX) begin
                                    level_d  = level_q - 4'd1;
                                    dir_dn_d = 1'b1;
                                 end else begin
                                    level_d = level_q + 4'd1;
                                 end
                              end else begin
                                 if (level_q == 4'd0) begin
                                    level_d  = 4'd1;
                                    dir_dn_d = 1'b0;
                                 end else begin
                                    level_d = level_q - 4'd1;
                                 end
                              end
                              duty_d = level_d;
                           end else begin
                              step_d = step_q + STEP_W'(1);
                           end
                        end
                     endcase
                  end
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State, pattern and LED registers
   always_ff @(posedge Clk_50M) begin
      if (Rst) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_FIX10;
         duty_q   <= '0;
         level_q  <= '0;
         dir_dn_q <= 1'b0;
         step_q   <= '0;
         led_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         duty_q   <= duty_d;
         level_q  <= level_d;
         dir_dn_q <= dir_dn_d;
         step_q   <= step_d;
         led_q    <= led_d;
      end
   end

   assign bus.Led        = led_q;
   assign bus.Duty       = duty_q;
   assign bus.Frame_tick = frame_tick;

endmodule
`default_nettype wire
